// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BURST
  } state_t;

  typedef enum logic {
    OWN_F,
    OWN_D
  } owner_t;

  localparam int unsigned MAX_BURST = 8;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, debug and ROM-side signals of the instruction-memory arbiter.
// slave: the arbiter. master: the requesters plus the ROM.
interface imem_arbiter_if #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 6
);

  logic         f_req;
  logic [A-1:0] f_addr;
  logic         f_gnt;
  logic         f_rvalid;
  logic [N-1:0] f_rdata;

  logic         d_req;
  logic [A-1:0] d_addr;
  logic [2:0]   d_len;
  logic         d_gnt;
  logic         d_rvalid;
  logic [N-1:0] d_rdata;
  logic         d_last;

  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_q;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_len, mem_q,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_last, mem_addr
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_len, mem_q,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_last, mem_addr
  );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: req[0] is fetch, req[1] is debug.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] gnt
);

  // On a tie the port that did not own the ROM last wins.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction ROM between fetch (single words) and
// debug (1-8 word wrapping bursts). Read data is registered one cycle later.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned A = 6
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  state_t       state, state_nxt;
  owner_t       last_owner, last_owner_nxt;
  logic [A-1:0] beat_addr, beat_addr_nxt;
  logic [2:0]   beats_left, beats_left_nxt;
  logic [1:0]   pick;
  logic         f_acc, d_acc, last_beat;

  rr_arb2 u_rr (
    .req        ({bus.d_req, bus.f_req}),
    .last_owner (last_owner),
    .gnt        (pick)
  );

  // State, ownership and burst bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWN_D;
      beat_addr  <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_addr  <= beat_addr_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  // Next-state, grants and ROM address.
  // beat_addr is loaded with d_addr+1 at grant, so it always points at the
  // next beat to issue; beats_left counts beats still to issue after the
  // current one, making beats_left==1 in BURST the final beat.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_addr_nxt  = beat_addr;
    beats_left_nxt = beats_left;
    bus.f_gnt      = 1'b0;
    bus.d_gnt      = 1'b0;
    bus.mem_addr   = '0;
    f_acc          = 1'b0;
    d_acc          = 1'b0;
    last_beat      = 1'b0;
    case (state)
      BURST: begin
        d_acc          = 1'b1;
        bus.mem_addr   = beat_addr;
        beat_addr_nxt  = A'(beat_addr + 1'b1);
        beats_left_nxt = 3'(beats_left - 3'd1);
        if (beats_left == 3'd1) begin
          last_beat = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        if (pick[0]) begin
          bus.f_gnt      = 1'b1;
          f_acc          = 1'b1;
          bus.mem_addr   = bus.f_addr;
          state_nxt      = FETCH;
          last_owner_nxt = OWN_F;
        end else if (pick[1]) begin
          bus.d_gnt      = 1'b1;
          d_acc          = 1'b1;
          bus.mem_addr   = bus.d_addr;
          beat_addr_nxt  = A'(bus.d_addr + 1'b1);
          beats_left_nxt = bus.d_len;
          last_owner_nxt = OWN_D;
          if (bus.d_len == 3'd0) begin
            last_beat = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = BURST;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Capture ROM data into the owning port and pulse its valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.f_rvalid <= 1'b0;
      bus.f_rdata  <= '0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= '0;
      bus.d_last   <= 1'b0;
    end else begin
      bus.f_rvalid <= f_acc;
      bus.d_rvalid <= d_acc;
      bus.d_last   <= d_acc & last_beat;
      if (f_acc) bus.f_rdata <= bus.mem_q;
      if (d_acc) bus.d_rdata <= bus.mem_q;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a per-cycle vector table plus
// hand-written sequences for tie alternation, long-burst stall and reset
// mid-burst.
module tb_imem_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  imem_arbiter_if #(.N(32), .A(6)) bus ();

  imem_arbiter #(.N(32), .A(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rom(input logic [5:0] a);
    return {8'hA5, 2'b00, a, 2'b00, ~a, 8'h3C ^ {2'b00, a}};
  endfunction

  assign bus.mem_q = rom(bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f_req;
    logic [5:0] f_addr;
    logic       d_req;
    logic [5:0] d_addr;
    logic [2:0] d_len;
    logic       f_gnt;
    logic       d_gnt;
    logic [5:0] mem_addr;
    logic       f_rv;
    logic [5:0] f_ra;
    logic       d_rv;
    logic [5:0] d_ra;
    logic       d_last;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic fr, input logic [5:0] fa, input logic dr,
                              input logic [5:0] da, input logic [2:0] dl,
                              input logic fg, input logic dg, input logic [5:0] ma,
                              input logic frv, input logic [5:0] fra,
                              input logic drv, input logic [5:0] dra, input logic dlst);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da; v.d_len = dl;
    v.f_gnt = fg; v.d_gnt = dg; v.mem_addr = ma;
    v.f_rv = frv; v.f_ra = fra; v.d_rv = drv; v.d_ra = dra; v.d_last = dlst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [5:0] fa, input logic dr,
                       input logic [5:0] da, input logic [2:0] dl);
    bus.f_req = fr; bus.f_addr = fa; bus.d_req = dr; bus.d_addr = da; bus.d_len = dl;
  endtask

  task automatic apply_row(input vec_t v, input int i);
    @(negedge clk);
    drive(v.f_req, v.f_addr, v.d_req, v.d_addr, v.d_len);
    #1;
    chk($sformatf("row%0d f_gnt", i), 32'(bus.f_gnt), 32'(v.f_gnt));
    chk($sformatf("row%0d d_gnt", i), 32'(bus.d_gnt), 32'(v.d_gnt));
    chk($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(v.mem_addr));
    chk($sformatf("row%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(v.f_rv));
    chk($sformatf("row%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(v.d_rv));
    chk($sformatf("row%0d d_last", i), 32'(bus.d_last), 32'(v.d_last));
    if (v.f_rv) chk($sformatf("row%0d f_rdata", i), bus.f_rdata, rom(v.f_ra));
    if (v.d_rv) chk($sformatf("row%0d d_rdata", i), bus.d_rdata, rom(v.d_ra));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            fr fa  dr da  dl  fg dg mem frv fra drv dra dlast
    vecs[0]  = mk(1, 5,  0, 0,  0,  1, 0, 5,  0, 0,  0, 0,  0);
    vecs[1]  = mk(1, 5,  0, 0,  0,  1, 0, 5,  1, 5,  0, 0,  0);
    vecs[2]  = mk(1, 5,  0, 0,  0,  1, 0, 5,  1, 5,  0, 0,  0);
    vecs[3]  = mk(0, 0,  0, 0,  0,  0, 0, 0,  1, 5,  0, 0,  0);
    vecs[4]  = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  0);
    vecs[5]  = mk(0, 0,  1, 62, 3,  0, 1, 62, 0, 0,  0, 0,  0);
    vecs[6]  = mk(0, 0,  0, 0,  0,  0, 0, 63, 0, 0,  1, 62, 0);
    vecs[7]  = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  1, 63, 0);
    vecs[8]  = mk(0, 0,  0, 0,  0,  0, 0, 1,  0, 0,  1, 0,  0);
    vecs[9]  = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  1, 1,  1);
    vecs[10] = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  0);
    vecs[11] = mk(0, 0,  1, 10, 0,  0, 1, 10, 0, 0,  0, 0,  0);
    vecs[12] = mk(1, 7,  0, 0,  0,  1, 0, 7,  0, 0,  1, 10, 1);
    vecs[13] = mk(0, 0,  0, 0,  0,  0, 0, 0,  1, 7,  0, 0,  0);
    vecs[14] = mk(1, 3,  1, 20, 0,  0, 1, 20, 0, 0,  0, 0,  0);
    vecs[15] = mk(1, 3,  1, 20, 0,  1, 0, 3,  0, 0,  1, 20, 1);
    vecs[16] = mk(1, 3,  1, 20, 0,  0, 1, 20, 1, 3,  0, 0,  0);
    vecs[17] = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  1, 20, 1);
    vecs[18] = mk(0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0,  0);

    reset = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("reset f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("reset d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("reset f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("reset d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("reset d_last", 32'(bus.d_last), 32'd0);
    chk("reset f_rdata", bus.f_rdata, 32'd0);
    chk("reset d_rdata", bus.d_rdata, 32'd0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) apply_row(vecs[i], i);

    // Both requesting from reset: fetch, debug, fetch, debug.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 6'd1, 1'b1, 6'd40, 3'd0);
      #1;
      chk($sformatf("tie%0d f_gnt", k), 32'(bus.f_gnt), 32'((k % 2) == 0));
      chk($sformatf("tie%0d d_gnt", k), 32'(bus.d_gnt), 32'((k % 2) == 1));
    end

    // Fetch wins this tie; debug then wins with an 8-word burst at 60.
    @(negedge clk);
    drive(1'b1, 6'd9, 1'b1, 6'd60, 3'd7);
    #1;
    chk("stall pre f_gnt", 32'(bus.f_gnt), 32'd1);
    @(negedge clk);
    #1;
    chk("stall t d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("stall t f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("stall t mem_addr", 32'(bus.mem_addr), 32'd60);
    for (int j = 0; j < 7; j++) begin
      logic [5:0] ea;
      ea = 6'(61 + j);
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d f_gnt", j), 32'(bus.f_gnt), 32'd0);
      chk($sformatf("stall%0d d_gnt", j), 32'(bus.d_gnt), 32'd0);
      chk($sformatf("stall%0d mem_addr", j), 32'(bus.mem_addr), 32'(ea));
      chk($sformatf("stall%0d d_last", j), 32'(bus.d_last), 32'd0);
      chk($sformatf("stall%0d both rvalid", j), 32'(bus.f_rvalid & bus.d_rvalid), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("stall end f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("stall end d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("stall end mem_addr", 32'(bus.mem_addr), 32'd9);
    chk("stall end d_last", 32'(bus.d_last), 32'd1);
    chk("stall end d_rdata", bus.d_rdata, rom(6'd3));
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0);
    #1;
    chk("stall idle f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("stall idle f_rdata", bus.f_rdata, rom(6'd9));

    // Reset during the third beat of a 6-beat burst at 30.
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 6'd30, 3'd5);
    #1;
    chk("abort d_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0);
    #1;
    chk("abort beat2 mem_addr", 32'(bus.mem_addr), 32'd31);
    @(negedge clk);
    #1;
    chk("abort beat3 mem_addr", 32'(bus.mem_addr), 32'd32);
    chk("abort beat3 d_rvalid", 32'(bus.d_rvalid), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort rst d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("abort rst f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("abort rst d_last", 32'(bus.d_last), 32'd0);
    chk("abort rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort rst d_rdata", bus.d_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post%0d d_rvalid", k), 32'(bus.d_rvalid), 32'd0);
      chk($sformatf("post%0d mem_addr", k), 32'(bus.mem_addr), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single-read-port instruction ROM between the processor fetch stage and a debug/readback port. Fetch issues single-word reads; debug issues bursts of 1–8 consecutive words with address wrap-around. Round-robin arbitration prevents either side from starving the other. The block sits between the fetch logic and the instruction memory and drives the ROM address. Read data is registered and returned one cycle after the grant.

## Interface
- `N`, 32, instruction word width
- `A`, 6, ROM address width (64 words)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `f_req`  in  1  fetch read request
- `f_addr`  in  A  fetch word address
- `f_gnt`  out  1  fetch request accepted this cycle
- `f_rvalid`  out  1  fetch read data valid
- `f_rdata`  out  N  fetch read data
- `d_req`  in  1  debug burst request
- `d_addr`  in  A  debug burst base address
- `d_len`  in  3  burst length minus one (0 → 1 word, 7 → 8 words)
- `d_gnt`  out  1  debug burst accepted this cycle
- `d_rvalid`  out  1  debug beat valid
- `d_rdata`  out  N  debug beat data
- `d_last`  out  1  final beat of burst (qualified by `d_rvalid`)
- `mem_addr`  out  A  ROM address
- `mem_q`  in  N  ROM data, combinational from `mem_addr`

## Operation
- FSM states: IDLE, FETCH, BURST.
- IDLE/FETCH: arbitrate every cycle.
  - Only `f_req` → grant fetch.
  - Only `d_req` → grant debug.
  - Both → grant the port that is not `last_owner`.
  - Neither → IDLE.
- Fetch grant:
  - `f_gnt`=1 combinationally in the same cycle; `mem_addr`=`f_addr`.
  - Next state FETCH.
  - `last_owner` ← fetch.
- Debug grant:
  - `d_gnt`=1 for exactly one cycle.
  - Latch `d_addr` into `beat_addr` and `d_len` into `beats_left`; `mem_addr`=`d_addr`.
  - `last_owner` ← debug.
  - If `d_len`=0, next state FETCH/IDLE per the normal rule; otherwise BURST.
- BURST:
  - Each cycle: `beat_addr` += 1 (mod 2^A, 63 → 0); `mem_addr`=`beat_addr`; `beats_left` -= 1.
  - Leave BURST when `beats_left` reaches 0.
  - No arbitration in BURST: `f_gnt`=0 and `d_gnt`=0 regardless of requests.
  - Arbitration resumes on the cycle after the last beat address is issued.
- Requesters hold `req`/`addr`/`len` stable until they see `gnt`. Changes before grant are legal, and the value present in the grant cycle is used.
- `mem_addr`=0 in any cycle with no access.
- Read data: `mem_q` is registered into the owning port's `rdata` at the end of every access cycle.
  - That port's `rvalid` pulses on the following cycle.
  - `rdata` holds its value until that port's next valid beat.
- `d_last`=1 on the `d_rvalid` cycle of the beat issued with `beats_left`=0.

## Timing
- Reset (`reset`=0), asynchronous:
  - State IDLE; `last_owner`=debug, so fetch wins the first tie.
  - `f_gnt`, `d_gnt`, `f_rvalid`, `d_rvalid`, `d_last` = 0.
  - `f_rdata`, `d_rdata` = 0; `mem_addr` = 0.
- Reset asserted mid-burst aborts the burst. No further `d_rvalid` pulses follow, and the requester must re-request.
- Latency: grant at cycle t → `rvalid` at t+1.
  - Fetch throughput is one word per cycle when debug is idle.
- An N-word burst granted at t occupies the ROM for cycles t..t+N-1.
  - Its beats arrive on t+1..t+N, with `d_last` at t+N.
- Worst-case fetch stall is 8 cycles: one maximal debug burst.
  - Round-robin then guarantees fetch the next grant if `f_req` is held.
- `f_rvalid` and `d_rvalid` are never high in the same cycle.

## Structure
- Package `imem_arb_pkg`: state enum (IDLE, FETCH, BURST), owner enum (OWN_F, OWN_D), and the constant `MAX_BURST`=8.
- Sub-module `rr_arb2`: combinational two-requester round-robin pick from `req[1:0]` and `last_owner`. The FSM, burst counter and data registers live in `imem_arbiter`.

## Test plan
- Reset then `f_req`=1, `f_addr`=5 held for 3 cycles → `f_gnt`=1 each cycle; `f_rvalid`=1 at t+1..t+3 with `f_rdata`=rom[5].
- `d_req`, `d_addr`=62, `d_len`=3 → `mem_addr` sequence 62, 63, 0, 1; `d_rdata` = rom[62], rom[63], rom[0], rom[1]; `d_last` only on rom[1].
- `f_req` and `d_req` both high from reset → fetch granted first, then debug, then fetch: alternation holds while both are held.
- `f_req` held during a `d_len`=7 burst → `f_gnt`=0 for 8 cycles, then `f_gnt`=1 on the next cycle even though `d_req` is still high.
- `reset`=0 asserted at the third beat of a 6-beat burst → all valids drop immediately; after release, no stale `d_rvalid`; `mem_addr`=0.
- `d_len`=0 at `d_addr`=10 → single beat with `d_rvalid`=`d_last`=1 at t+1 and `d_rdata`=rom[10]; a fetch can be granted at t+1.
